free_list: RTL and testbench

FREE_LIST -- requirements
Module: free_list

---
 rtl/free_list_if.sv | 41 ++++
 rtl/free_list.sv | 102 ++++++++++
 tb/tb_free_list.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/free_list_if.sv
// Dispatch, retire and recovery signals of the physical-tag free list,
// plus read-only views of its pointers for checkers.
`ifndef SYS_PHYS_REG
`define SYS_PHYS_REG 6
`endif
`ifndef SYS_ROB_ADDR_WIDTH
`define SYS_ROB_ADDR_WIDTH 5
`endif

// Handshake: dis_alloc_en[s] is a request with no stall. Counting requesting
// slots from slot 2 down, a slot is granted when its rank is below
// fl_avail_cnt, and only then is fl_alloc_tag[s] meaningful (else 0).
// fl_retire_en_mask[s] is a valid-only push with no backpressure.
interface free_list_if;
  logic [2:0]                          dis_alloc_en;
  logic [2:0][`SYS_PHYS_REG-1:0]       fl_alloc_tag;
  logic [1:0]                          fl_avail_cnt;
  logic [2:0]                          fl_retire_en_mask;
  logic [2:0][`SYS_PHYS_REG-1:0]       fl_retire_tag;
  logic                                fch_rec_enable;
  logic [`SYS_ROB_ADDR_WIDTH:0]        fl_recover_dis;
  logic [`SYS_ROB_ADDR_WIDTH:0]        fl_free_count;
  logic                                fl_overflow_err;
  logic [`SYS_ROB_ADDR_WIDTH-1:0]      dbg_head;
  logic [`SYS_ROB_ADDR_WIDTH-1:0]      dbg_tail;
  logic [`SYS_ROB_ADDR_WIDTH:0]        dbg_valid_count;

  modport master (
    output dis_alloc_en, fl_retire_en_mask, fl_retire_tag,
           fch_rec_enable, fl_recover_dis,
    input  fl_alloc_tag, fl_avail_cnt, fl_free_count, fl_overflow_err,
           dbg_head, dbg_tail, dbg_valid_count
  );

  modport slave (
    input  dis_alloc_en, fl_retire_en_mask, fl_retire_tag,
           fch_rec_enable, fl_recover_dis,
    output fl_alloc_tag, fl_avail_cnt, fl_free_count, fl_overflow_err,
           dbg_head, dbg_tail, dbg_valid_count
  );
endinterface

// File: rtl/free_list.sv
// Circular free list of physical register tags: three allocations and three
// retire-time releases per cycle, with head rollback on precise-state recovery.
module free_list #(
  parameter int FL_DEPTH = 32
) (
  input  logic       clock,
  input  logic       reset,
  free_list_if.slave fl
);
  // Pointers wrap by natural overflow, so FL_DEPTH must be a power of two.
  localparam int PW = $clog2(FL_DEPTH);
  localparam int AW = `SYS_ROB_ADDR_WIDTH;
  localparam int TW = `SYS_PHYS_REG;
  localparam int CW = AW + 1;
  localparam int SW = CW + 2;

  logic [TW-1:0]        tag_mem [FL_DEPTH];
  logic [PW-1:0]        head, tail, head_next;
  logic [CW-1:0]        valid_count, inflight, valid_next, inflight_next;
  logic                 overflow_err;
  logic [1:0]           avail, grant_cnt, push_cnt;
  logic [PW-1:0]        push_ptr [3];
  logic [2:0][TW-1:0]   alloc_tag;
  logic [SW-1:0]        valid_sum, inflight_sum;
  logic                 valid_over;

  always_comb begin
    avail = (valid_count > CW'(3)) ? 2'd3 : valid_count[1:0];
    if (fl.fch_rec_enable && reset) avail = 2'd0;
  end

  // Grants are taken strictly from registered entries; a same-cycle push is
  // never visible here. Reset suppresses every grant.
  always_comb begin
    grant_cnt = 2'd0;
    alloc_tag = '0;
    for (int s = 2; s >= 0; s--) begin
      if (reset && fl.dis_alloc_en[s] && (grant_cnt < avail)) begin
        alloc_tag[s] = tag_mem[head + PW'(grant_cnt)];
        grant_cnt    = grant_cnt + 2'd1;
      end
    end
  end

  always_comb begin
    push_cnt = 2'd0;
    for (int s = 2; s >= 0; s--) begin
      push_ptr[s] = tail + PW'(push_cnt);
      if (fl.fl_retire_en_mask[s]) push_cnt = push_cnt + 2'd1;
    end
  end

  always_comb begin
    inflight_sum = SW'(inflight) + SW'(grant_cnt);
    if (fl.fch_rec_enable) begin
      head_next     = head - PW'(fl.fl_recover_dis);
      valid_sum     = SW'(valid_count) + SW'(fl.fl_recover_dis) + SW'(push_cnt);
      inflight_next = '0;
    end else begin
      head_next = head + PW'(grant_cnt);
      valid_sum = SW'(valid_count) - SW'(grant_cnt) + SW'(push_cnt);
      if (inflight_sum < SW'(push_cnt))
        inflight_next = '0;
      else if (inflight_sum - SW'(push_cnt) > SW'(FL_DEPTH))
        inflight_next = CW'(FL_DEPTH);
      else
        inflight_next = CW'(inflight_sum - SW'(push_cnt));
    end
    valid_over = valid_sum > SW'(FL_DEPTH);
    valid_next = valid_over ? CW'(FL_DEPTH) : valid_sum[CW-1:0];
  end

  // Architectural tags occupy the low half of the tag space; the free list
  // starts holding the upper FL_DEPTH tags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FL_DEPTH; i++)
        tag_mem[i] <= TW'(2**TW - FL_DEPTH + i);
      head         <= '0;
      tail         <= '0;
      valid_count  <= CW'(FL_DEPTH);
      inflight     <= '0;
      overflow_err <= 1'b0;
    end else begin
      for (int s = 0; s < 3; s++)
        if (fl.fl_retire_en_mask[s]) tag_mem[push_ptr[s]] <= fl.fl_retire_tag[s];
      head        <= head_next;
      tail        <= tail + PW'(push_cnt);
      valid_count <= valid_next;
      inflight    <= inflight_next;
      if (valid_over) overflow_err <= 1'b1;
    end
  end

  assign fl.fl_alloc_tag    = alloc_tag;
  assign fl.fl_avail_cnt    = avail;
  assign fl.fl_free_count   = inflight;
  assign fl.fl_overflow_err = overflow_err;
  assign fl.dbg_head        = AW'(head);
  assign fl.dbg_tail        = AW'(tail);
  assign fl.dbg_valid_count = valid_count;
endmodule

// File: tb/tb_free_list.sv
// Bench for free_list: vector table, directed corner sequences and a
// randomized run against an array-based reference model.
`ifndef SYS_PHYS_REG
`define SYS_PHYS_REG 6
`endif
`ifndef SYS_ROB_ADDR_WIDTH
`define SYS_ROB_ADDR_WIDTH 5
`endif

module tb_free_list;
  localparam int DEPTH = 32;

  logic clock, reset;
  free_list_if fl_if ();

  free_list #(.FL_DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .fl    (fl_if)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic zero_inputs();
    fl_if.dis_alloc_en      = 3'b000;
    fl_if.fl_retire_en_mask = 3'b000;
    fl_if.fl_retire_tag     = '0;
    fl_if.fch_rec_enable    = 1'b0;
    fl_if.fl_recover_dis    = '0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    zero_inputs();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  // One clock per call: inputs applied at the falling edge, consumed by the
  // following rising edge; outputs are checkable after the #1.
  task automatic drive(input logic [2:0] en, input logic [2:0] mask,
                       input logic [5:0] t2, input logic [5:0] t1, input logic [5:0] t0,
                       input logic rec, input logic [5:0] dis);
    @(negedge clock);
    fl_if.dis_alloc_en      = en;
    fl_if.fl_retire_en_mask = mask;
    fl_if.fl_retire_tag[2]  = t2;
    fl_if.fl_retire_tag[1]  = t1;
    fl_if.fl_retire_tag[0]  = t0;
    fl_if.fch_rec_enable    = rec;
    fl_if.fl_recover_dis    = dis;
    #1;
  endtask

  task automatic chk_tags(input string name, input int e2, input int e1, input int e0);
    chk({name, ".tag2"}, 32'(fl_if.fl_alloc_tag[2]), 32'(e2));
    chk({name, ".tag1"}, 32'(fl_if.fl_alloc_tag[1]), 32'(e1));
    chk({name, ".tag0"}, 32'(fl_if.fl_alloc_tag[0]), 32'(e0));
  endtask

  // Reference model: the free list as an array of tags with modular indices.
  int m_mem [DEPTH];
  int m_head, m_tail, m_vc, m_inf;
  bit m_err;

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 32 + i;
    m_head = 0; m_tail = 0; m_vc = DEPTH; m_inf = 0; m_err = 0;
  endfunction

  typedef struct {
    logic [2:0] en;
    logic [2:0] mask;
    logic [5:0] t2, t1, t0;
    int e2, e1, e0, e_avail, e_free, e_vc, e_head, e_tail;
  } vec_t;

  vec_t vt [6];

  initial begin
    reset = 1'b1;
    zero_inputs();
    #2 reset = 1'b0;
    #1;
    chk("async_reset.avail", 32'(fl_if.fl_avail_cnt), 3);
    chk("async_reset.free", 32'(fl_if.fl_free_count), 0);
    chk("async_reset.vc", 32'(fl_if.dbg_valid_count), 32);
    chk("async_reset.err", 32'(fl_if.fl_overflow_err), 0);
    do_reset();

    // ---- vector table: consecutive cycles from reset ----
    vt[0] = '{3'b111, 3'b000, 0, 0, 0, 32, 33, 34, 3, 0, 32, 0, 0};
    vt[1] = '{3'b101, 3'b000, 0, 0, 0, 35,  0, 36, 3, 3, 29, 3, 0};
    vt[2] = '{3'b000, 3'b100, 5, 0, 0,  0,  0,  0, 3, 5, 27, 5, 0};
    vt[3] = '{3'b000, 3'b011, 0, 7, 9,  0,  0,  0, 3, 4, 28, 5, 1};
    vt[4] = '{3'b010, 3'b000, 0, 0, 0,  0, 37,  0, 3, 2, 30, 5, 3};
    vt[5] = '{3'b000, 3'b000, 0, 0, 0,  0,  0,  0, 3, 3, 29, 6, 3};
    for (int i = 0; i < 6; i++) begin
      drive(vt[i].en, vt[i].mask, vt[i].t2, vt[i].t1, vt[i].t0, 1'b0, 6'd0);
      chk_tags($sformatf("vec%0d", i), vt[i].e2, vt[i].e1, vt[i].e0);
      chk($sformatf("vec%0d.avail", i), 32'(fl_if.fl_avail_cnt), 32'(vt[i].e_avail));
      chk($sformatf("vec%0d.free", i), 32'(fl_if.fl_free_count), 32'(vt[i].e_free));
      chk($sformatf("vec%0d.vc", i), 32'(fl_if.dbg_valid_count), 32'(vt[i].e_vc));
      chk($sformatf("vec%0d.head", i), 32'(fl_if.dbg_head), 32'(vt[i].e_head));
      chk($sformatf("vec%0d.tail", i), 32'(fl_if.dbg_tail), 32'(vt[i].e_tail));
    end

    // ---- sparse grant, release to entry 0, then drain to a single tag ----
    do_reset();
    drive(3'b101, 3'b000, 0, 0, 0, 1'b0, 6'd0);
    chk_tags("sparse", 32, 0, 33);
    drive(3'b000, 3'b100, 5, 0, 0, 1'b0, 6'd0);
    chk("sparse.free_before", 32'(fl_if.fl_free_count), 2);
    drive(3'b000, 3'b000, 0, 0, 0, 1'b0, 6'd0);
    chk("sparse.free_after", 32'(fl_if.fl_free_count), 1);
    chk("sparse.tail", 32'(fl_if.dbg_tail), 1);
    for (int i = 0; i < 10; i++) begin
      drive(3'b111, 3'b000, 0, 0, 0, 1'b0, 6'd0);
      chk($sformatf("drain%0d.tag2", i), 32'(fl_if.fl_alloc_tag[2]), 32'(34 + 3 * i));
      chk($sformatf("drain%0d.tag0", i), 32'(fl_if.fl_alloc_tag[0]), 32'(36 + 3 * i));
    end
    drive(3'b111, 3'b100, 12, 0, 0, 1'b0, 6'd0);
    chk("last_one.avail", 32'(fl_if.fl_avail_cnt), 1);
    chk_tags("last_one", 5, 0, 0);
    drive(3'b100, 3'b000, 0, 0, 0, 1'b0, 6'd0);
    chk("after_push.vc", 32'(fl_if.dbg_valid_count), 1);
    chk("after_push.avail", 32'(fl_if.fl_avail_cnt), 1);
    chk("after_push.free", 32'(fl_if.fl_free_count), 31);
    chk_tags("after_push", 12, 0, 0);

    // ---- recovery rollback with simultaneous retire pushes ----
    do_reset();
    drive(3'b111, 3'b000, 0, 0, 0, 1'b0, 6'd0);
    chk_tags("rec_alloc_a", 32, 33, 34);
    drive(3'b111, 3'b000, 0, 0, 0, 1'b0, 6'd0);
    chk_tags("rec_alloc_b", 35, 36, 37);
    drive(3'b111, 3'b110, 7, 9, 0, 1'b1, 6'd4);
    chk("rec.avail", 32'(fl_if.fl_avail_cnt), 0);
    chk_tags("rec", 0, 0, 0);
    chk("rec.free_before", 32'(fl_if.fl_free_count), 6);
    drive(3'b100, 3'b000, 0, 0, 0, 1'b0, 6'd0);
    chk("rec.head", 32'(fl_if.dbg_head), 2);
    chk("rec.vc", 32'(fl_if.dbg_valid_count), 32);
    chk("rec.free", 32'(fl_if.fl_free_count), 0);
    chk("rec.err", 32'(fl_if.fl_overflow_err), 0);
    chk_tags("rec_regrant", 34, 0, 0);

    // ---- head and tail wrap within one cycle ----
    do_reset();
    for (int i = 0; i < 10; i++) drive(3'b111, 3'b000, 0, 0, 0, 1'b0, 6'd0);
    drive(3'b100, 3'b111, 10, 11, 12, 1'b0, 6'd0);
    chk("wrap.head30", 32'(fl_if.dbg_head), 30);
    chk_tags("wrap_pre", 62, 0, 0);
    drive(3'b111, 3'b000, 0, 0, 0, 1'b0, 6'd0);
    chk("wrap.head31", 32'(fl_if.dbg_head), 31);
    chk_tags("wrap_head", 63, 10, 11);
    for (int i = 0; i < 9; i++) drive(3'b000, 3'b111, 40, 41, 42, 1'b0, 6'd0);
    drive(3'b000, 3'b111, 20, 21, 22, 1'b0, 6'd0);
    chk("wrap.tail30", 32'(fl_if.dbg_tail), 30);
    drive(3'b000, 3'b000, 0, 0, 0, 1'b0, 6'd0);
    chk("wrap.tail1", 32'(fl_if.dbg_tail), 1);
    chk("wrap.vc", 32'(fl_if.dbg_valid_count), 31);
    for (int i = 0; i < 9; i++) drive(3'b111, 3'b000, 0, 0, 0, 1'b0, 6'd0);
    drive(3'b100, 3'b000, 0, 0, 0, 1'b0, 6'd0);
    drive(3'b111, 3'b000, 0, 0, 0, 1'b0, 6'd0);
    chk("wrap.head_at30", 32'(fl_if.dbg_head), 30);
    chk_tags("wrap_tail", 20, 21, 22);

    // ---- overflow is sticky until an asynchronous reset ----
    do_reset();
    drive(3'b000, 3'b100, 1, 0, 0, 1'b0, 6'd0);
    chk("ovf.before", 32'(fl_if.fl_overflow_err), 0);
    drive(3'b000, 3'b000, 0, 0, 0, 1'b0, 6'd0);
    chk("ovf.set", 32'(fl_if.fl_overflow_err), 1);
    chk("ovf.vc_sat", 32'(fl_if.dbg_valid_count), 32);
    chk("ovf.tail", 32'(fl_if.dbg_tail), 1);
    drive(3'b000, 3'b000, 0, 0, 0, 1'b0, 6'd0);
    chk("ovf.held", 32'(fl_if.fl_overflow_err), 1);
    drive(3'b111, 3'b111, 3, 4, 5, 1'b1, 6'd3);
    reset = 1'b0;
    #1;
    chk("midrst.err", 32'(fl_if.fl_overflow_err), 0);
    chk("midrst.avail", 32'(fl_if.fl_avail_cnt), 3);
    chk("midrst.free", 32'(fl_if.fl_free_count), 0);
    chk("midrst.head", 32'(fl_if.dbg_head), 0);
    chk("midrst.tail", 32'(fl_if.dbg_tail), 0);
    chk_tags("midrst", 0, 0, 0);
    @(negedge clock);
    zero_inputs();
    @(negedge clock);
    reset = 1'b1;
    drive(3'b000, 3'b000, 0, 0, 0, 1'b0, 6'd0);
    chk("postrst.head", 32'(fl_if.dbg_head), 0);
    chk("postrst.tail", 32'(fl_if.dbg_tail), 0);
    chk("postrst.vc", 32'(fl_if.dbg_valid_count), 32);
    chk("postrst.err", 32'(fl_if.fl_overflow_err), 0);

    // ---- randomized run against the reference model ----
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [2:0] en, mask;
      logic [5:0] t2, t1, t0, dis;
      logic       rec;
      int         avail, req, g, p, nvc;
      int         exp_tag [3];
      int         tags_in [3];
      en   = 3'($urandom_range(0, 7));
      mask = 3'($urandom_range(0, 7));
      rec  = ($urandom_range(0, 15) == 0);
      dis  = 6'($urandom_range(0, m_inf + 1));
      t2 = 6'($urandom_range(0, 63));
      t1 = 6'($urandom_range(0, 63));
      t0 = 6'($urandom_range(0, 63));
      if ($countones(mask) > m_inf) mask = 3'b000;
      drive(en, mask, t2, t1, t0, rec, dis);

      avail = rec ? 0 : (m_vc < 3 ? m_vc : 3);
      req = 0;
      for (int s = 2; s >= 0; s--) begin
        exp_tag[s] = 0;
        if (en[s]) begin
          if (req < avail) exp_tag[s] = m_mem[(m_head + req) % DEPTH];
          req++;
        end
      end
      g = (req < avail) ? req : avail;
      chk_tags($sformatf("rnd%0d", cyc), exp_tag[2], exp_tag[1], exp_tag[0]);
      chk($sformatf("rnd%0d.avail", cyc), 32'(fl_if.fl_avail_cnt), 32'(avail));
      chk($sformatf("rnd%0d.free", cyc), 32'(fl_if.fl_free_count), 32'(m_inf));
      chk($sformatf("rnd%0d.err", cyc), 32'(fl_if.fl_overflow_err), 32'(m_err));
      chk($sformatf("rnd%0d.vc", cyc), 32'(fl_if.dbg_valid_count), 32'(m_vc));
      chk($sformatf("rnd%0d.head", cyc), 32'(fl_if.dbg_head), 32'(m_head));
      chk($sformatf("rnd%0d.tail", cyc), 32'(fl_if.dbg_tail), 32'(m_tail));

      tags_in[2] = t2; tags_in[1] = t1; tags_in[0] = t0;
      p = 0;
      for (int s = 2; s >= 0; s--) begin
        if (mask[s]) begin
          m_mem[(m_tail + p) % DEPTH] = tags_in[s];
          p++;
        end
      end
      m_tail = (m_tail + p) % DEPTH;
      if (rec) begin
        m_head = (m_head - (int'(dis) % DEPTH) + DEPTH) % DEPTH;
        nvc    = m_vc + int'(dis) + p;
        m_inf  = 0;
      end else begin
        m_head = (m_head + g) % DEPTH;
        nvc    = m_vc - g + p;
        m_inf  = m_inf + g - p;
        if (m_inf < 0) m_inf = 0;
        if (m_inf > DEPTH) m_inf = DEPTH;
      end
      if (nvc > DEPTH) begin
        m_err = 1;
        nvc   = DEPTH;
      end
      m_vc = nvc;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
